// File: rtl/pipe_ex_hs.sv
// Three-stage handshaked datapath computing F = ((A+B) + (C-D)) * D with per-stage overflow tracking.
// Define PIPE_EX_SAT_EN to clamp each stage instead of wrapping modulo 2^N.
module pipe_ex_hs #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_c,
  input  logic [N-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_f,
  output logic         out_ovf,
  output logic [1:0]   occupancy
);

  logic         v1_q, v2_q, v3_q;
  logic [N-1:0] x1_q, x2_q, d1_q, x3_q, d2_q, f_q;
  logic         ovf1_q, ovf2_q, ovf3_q;
  logic [1:0]   occ_q, occ_d;

  logic         ld1, ld2, ld3;
  logic         in_xfer, out_xfer;
  logic [N:0]   s1_sum, s2_sum;
  logic [2*N-1:0] prod;
  logic         s1_lt, prod_big;
  logic [N-1:0] x1_d, x2_d, x3_d, f_d;
  logic         ovf1_d, ovf2_d, ovf3_d;

  // A stage may load whenever it is empty or its contents move on this edge.
  assign ld3      = !v3_q || out_ready;
  assign ld2      = !v2_q || ld3;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1;
  assign in_xfer  = in_valid && ld1;
  assign out_xfer = v3_q && out_ready;

  assign s1_sum   = {1'b0, in_a} + {1'b0, in_b};
  assign s1_lt    = in_c < in_d;
  assign s2_sum   = {1'b0, x1_q} + {1'b0, x2_q};
  assign prod     = {{N{1'b0}}, x3_q} * {{N{1'b0}}, d2_q};
  assign prod_big = |prod[2*N-1:N];

  always_comb begin
    ovf1_d = s1_sum[N] || s1_lt;
    ovf2_d = ovf1_q || s2_sum[N];
    ovf3_d = ovf2_q || prod_big;
`ifdef PIPE_EX_SAT_EN
    x1_d = s1_sum[N] ? {N{1'b1}} : s1_sum[N-1:0];
    x2_d = s1_lt ? '0 : (in_c - in_d);
    x3_d = s2_sum[N] ? {N{1'b1}} : s2_sum[N-1:0];
    f_d  = prod_big ? {N{1'b1}} : prod[N-1:0];
`else
    x1_d = s1_sum[N-1:0];
    x2_d = in_c - in_d;
    x3_d = s2_sum[N-1:0];
    f_d  = prod[N-1:0];
`endif
  end

  always_comb begin
    case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      x1_q   <= '0;
      x2_q   <= '0;
      d1_q   <= '0;
      x3_q   <= '0;
      d2_q   <= '0;
      f_q    <= '0;
      ovf1_q <= 1'b0;
      ovf2_q <= 1'b0;
      ovf3_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      occ_q <= occ_d;
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          x1_q   <= x1_d;
          x2_q   <= x2_d;
          d1_q   <= in_d;
          ovf1_q <= ovf1_d;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          x3_q   <= x3_d;
          d2_q   <= d1_q;
          ovf2_q <= ovf2_d;
        end
      end
      // Output register only changes when it is refilled with a real result.
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          f_q    <= f_d;
          ovf3_q <= ovf3_d;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_f     = f_q;
  assign out_ovf   = ovf3_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_ex_hs.sv
// Self-checking bench for pipe_ex_hs: queue-based reference model plus directed literal checks.
// Honours PIPE_EX_SAT_EN the same way as the design.
module tb_pipe_ex_hs;
  localparam int N = 10;
  localparam int MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic         in_ready, out_valid, out_ovf;
  logic [N-1:0] out_f;
  logic [1:0]   occupancy;

  pipe_ex_hs #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_ovf(out_ovf), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the definition of F.
  function automatic void ref_calc(input int a, input int b, input int c, input int d,
                                   output int f, output bit ovf);
    int s1, x1, x2, s2, x3, p;
    ovf = 1'b0;
    s1 = a + b;
    if (s1 > MAXV) ovf = 1'b1;
    if (c < d) ovf = 1'b1;
    s2 = 0;
`ifdef PIPE_EX_SAT_EN
    x1 = (s1 > MAXV) ? MAXV : s1;
    x2 = (c < d) ? 0 : c - d;
    s2 = x1 + x2;
    if (s2 > MAXV) ovf = 1'b1;
    x3 = (s2 > MAXV) ? MAXV : s2;
    p = x3 * d;
    if (p > MAXV) ovf = 1'b1;
    f = (p > MAXV) ? MAXV : p;
`else
    x1 = s1 % (MAXV + 1);
    x2 = (c - d + MAXV + 1) % (MAXV + 1);
    s2 = x1 + x2;
    if (s2 > MAXV) ovf = 1'b1;
    x3 = s2 % (MAXV + 1);
    p = x3 * d;
    if (p > MAXV) ovf = 1'b1;
    f = p % (MAXV + 1);
`endif
  endfunction

  // Model: results in flight in acceptance order, each with edges elapsed since acceptance.
  typedef struct {
    int f;
    bit ovf;
    int age;
  } item_t;
  item_t q[$];

  bit m_valid, m_ready, ix, ox;
  int mf;
  bit movf;

  always @(negedge clk) begin
    m_valid = (q.size() > 0) && (q[0].age >= 2);
    m_ready = !((q.size() == 3) && !out_ready);
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("occupancy", int'(occupancy), q.size());
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("out_f", int'(out_f), q[0].f);
        chk("out_ovf", int'(out_ovf), int'(q[0].ovf));
      end
    end
    if (!rst_n) begin
      q.delete();
    end else begin
      ox = m_valid && out_ready;
      ix = in_valid && m_ready;
      if (ox) begin
        void'(q.pop_front());
        n_out++;
      end
      foreach (q[i]) q[i].age++;
      if (ix) begin
        ref_calc(int'(in_a), int'(in_b), int'(in_c), int'(in_d), mf, movf);
        q.push_back('{f: mf, ovf: movf, age: 0});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int c, input int d);
    in_a = N'(a); in_b = N'(b); in_c = N'(c); in_d = N'(d);
  endtask

  task automatic send_one(input string name, input int a, input int b, input int c, input int d,
                          input int ef, input int eovf);
    tick();
    drive(a, b, c, d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_f"}, int'(out_f), ef);
    chk({name, "_ovf"}, int'(out_ovf), eovf);
  endtask

  int rf;
  bit rovf;
  int target, cycles;

  initial begin
    // Pin the model itself with hand-computed values.
    ref_calc(10, 12, 6, 3, rf, rovf); chk("model_75", rf, 75); chk("model_75_ovf", int'(rovf), 0);
    ref_calc(10, 10, 5, 3, rf, rovf); chk("model_66", rf, 66);
`ifdef PIPE_EX_SAT_EN
    ref_calc(20, 11, 1, 4, rf, rovf);  chk("model_124", rf, 124);  chk("model_124_ovf", int'(rovf), 1);
    ref_calc(500, 500, 10, 3, rf, rovf); chk("model_1023", rf, 1023);
`else
    ref_calc(20, 11, 1, 4, rf, rovf);  chk("model_112", rf, 112);  chk("model_112_ovf", int'(rovf), 1);
    ref_calc(500, 500, 10, 3, rf, rovf); chk("model_973", rf, 973);
`endif

    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_out_f", int'(out_f), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Back-to-back pair with exact latency.
    tick();
    drive(10, 12, 6, 3);
    in_valid = 1'b1;
    tick();
    drive(10, 10, 5, 3);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_early", int'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("b2b_first_valid", int'(out_valid), 1);
    chk("b2b_first_f", int'(out_f), 75);
    chk("b2b_first_ovf", int'(out_ovf), 0);
    tick();
    @(negedge clk);
    chk("b2b_second_valid", int'(out_valid), 1);
    chk("b2b_second_f", int'(out_f), 66);
    tick();
    tick();

`ifdef PIPE_EX_SAT_EN
    send_one("neg_diff", 20, 11, 1, 4, 124, 1);
    send_one("big_sum", 500, 500, 10, 3, 1023, 1);
`else
    send_one("neg_diff", 20, 11, 1, 4, 112, 1);
    send_one("big_sum", 500, 500, 10, 3, 973, 1);
`endif
    tick();
    tick();

    // Stalled output with continuous input: fill to three, hold first result.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) drive(i + 1, 2, 7, 1);
      tick();
    end
    @(negedge clk);
    chk("stall_occ", int'(occupancy), 3);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_hold_f", int'(out_f), 9);
    tick();
    tick();
    @(negedge clk);
    chk("stall_hold_f2", int'(out_f), 9);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (6) tick();

    // Reset while full and stalled: everything in flight is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(3, 4, 5, 2);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_full_valid", int'(out_valid), 0);
    chk("rst_full_occ", int'(occupancy), 0);
    chk("rst_full_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (4) tick();

    // Random handshaking over 1000 output transfers.
    target = n_out + 1000;
    cycles = 0;
    while (n_out < target && cycles < 30000) begin
      in_valid = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      drive(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
            int'($urandom_range(0, MAXV)), int'($urandom_range(0, 40)));
      tick();
      cycles++;
    end
    chk("random_done", int'(n_out >= target), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("drain_occ", int'(occupancy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ex_hs.md
PIPE_EX_HS -- requirements
Module: pipe_ex_hs

Interface
REQ-001 SHALL have parameter N, default 10, meaning data width of operands and result.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set A..D present.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have ports in_a, in_b, in_c, in_d  input  N each  unsigned operands.
REQ-007 SHALL have port out_valid  output  1  out_f/out_ovf hold a result.
REQ-008 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-009 SHALL have port out_f  output  N  result F.
REQ-010 SHALL have port out_ovf  output  1  result was wrapped (or clamped) in some stage.
REQ-011 SHALL have port occupancy  output  2  number of valid stages, 0..3.

Function
REQ-012 SHALL compute F = ((A+B) + (C-D)) * D, unsigned, in three registered stages: S1 x1=A+B, x2=C-D, d1=D; S2 x3=x1+x2, d2=d1; S3 F=x3*d2.
REQ-013 SHALL keep every intermediate N bits wide; default mode wraps modulo 2^N.
REQ-014 SHALL set out_ovf when any of: A+B carry out, C<D, x1+x2 carry out, or x3*d2 >= 2^N; flag travels with its data.
REQ-015 SHALL transfer input on rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-016 SHALL advance stage i when its successor is empty or advancing; S3 advances when out_ready or empty; in_ready = !S1_valid || S1 advancing (combinational, no bubble required).
REQ-017 SHALL give latency 3: operands accepted at edge k appear on out_valid/out_f after edge k+2 when never stalled.
REQ-018 SHALL sustain one result per cycle with out_ready held high.
REQ-019 SHALL hold out_f, out_ovf, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL fill empty stages while downstream stalled (bubble collapse), reaching occupancy 3 then deasserting in_ready.
REQ-021 SHALL update occupancy registered: +1 on input transfer, -1 on output transfer, unchanged on both or neither; never exceeds 3.
REQ-022 SHALL ignore in_a..in_d whenever in_valid is low or in_ready is low.

Reset
REQ-023 SHALL, on rising edge with rst_n low, clear all stage valids, out_valid=0, out_ovf=0, out_f=0, occupancy=0, discarding in-flight data.
REQ-024 SHALL drive in_ready=1 the cycle after reset releases; reset mid-stall drops data without emitting it.
REQ-025 SHALL not accept an input on an edge where rst_n is low.

Configuration
REQ-026 SHALL honour macro PIPE_EX_SAT_EN: when defined, each stage clamps instead of wrapping (sum to 2^N-1, C-D to 0, product to 2^N-1) and out_ovf marks clamping; when undefined, wrap per REQ-013.
REQ-027 SHALL keep identical handshake, latency and occupancy in both configurations.

Verification (N=10)
REQ-028 SHALL cover stream A=10,B=12,C=6,D=3 then 10,10,5,3 with out_ready=1 -> F=75 then 66, ovf=0, 3-cycle latency, back-to-back.
REQ-029 SHALL cover A=20,B=11,C=1,D=4 -> default F=112, ovf=1; PIPE_EX_SAT_EN F=124, ovf=1.
REQ-030 SHALL cover A=500,B=500,C=10,D=3 -> default F=973, ovf=1; PIPE_EX_SAT_EN F=1023, ovf=1.
REQ-031 SHALL cover out_ready=0 with continuous in_valid -> occupancy reaches 3, in_ready=0, out_f held; release out_ready -> results in order, none lost or duplicated.
REQ-032 SHALL cover rst_n low for one edge with occupancy=3 -> out_valid=0, occupancy=0, in_ready=1 next cycle, no stale result emitted.
REQ-033 SHALL cover random in_valid/out_ready over 1000 transfers against a reference model in both configurations.
